// File: rtl/interval_timer_bank.sv
// interval_timer_bank: NUM_PARAMS reprogrammable interval registers with an
// integrated countdown timer that loads the selected interval, decrements on
// each one-second tick and pulses expired for one cycle when it reaches zero.
//
// Optional build macro: TIMER_PARAM_LOCK_EN
//   When defined, reprogram writes are ignored while the timer is busy and
//   the reprogram_rejected output pulses for one cycle per ignored attempt.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-low reset
//   time_param_sel     register index for reprogram writes
//   time_value         data for reprogram writes
//   reprogram          write strobe, one write per cycle high
//   interval           register selected for readout and timer load
//   start_timer        load selected interval and start counting
//   tick               one-cycle one-second enable
//   value              combinational readout of register[interval]
//   remaining          current countdown value (registered)
//   busy               high while counting (registered)
//   expired            one-cycle completion pulse (registered)
//   reprogram_rejected write-ignored pulse (TIMER_PARAM_LOCK_EN only)
module interval_timer_bank #(
    parameter int unsigned                      NUM_PARAMS     = 4,
    parameter int unsigned                      VALUE_W        = 4,
    parameter logic [NUM_PARAMS*VALUE_W-1:0]    DEFAULT_VALUES = {4'd10, 4'd15, 4'd8, 4'd6},
    localparam int unsigned                     SEL_W          = $clog2(NUM_PARAMS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   time_param_sel,
    input  logic [VALUE_W-1:0] time_value,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   interval,
    input  logic               start_timer,
    input  logic               tick,
    output logic [VALUE_W-1:0] value,
`ifdef TIMER_PARAM_LOCK_EN
    output logic               reprogram_rejected,
`endif
    output logic [VALUE_W-1:0] remaining,
    output logic               busy,
    output logic               expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [VALUE_W-1:0] remaining_next;
    logic [VALUE_W-1:0] regs [NUM_PARAMS];
    logic               rd_ok_c;
    logic               wr_ok_c;
    logic               wr_en_c;

    // Index range checks done at 32 bits so non-power-of-two banks are safe
    assign rd_ok_c = (32'(interval) < NUM_PARAMS);
    assign wr_ok_c = (32'(time_param_sel) < NUM_PARAMS);
    assign value   = rd_ok_c ? regs[interval] : '0;

`ifdef TIMER_PARAM_LOCK_EN
    assign wr_en_c = reprogram && wr_ok_c && !busy;

    // One-cycle flag for each write attempt blocked by a running countdown
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reprogram_rejected <= 1'b0;
        end else begin
            reprogram_rejected <= reprogram && busy;
        end
    end
`else
    assign wr_en_c = reprogram && wr_ok_c;
`endif

    // Interval register bank
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                regs[i] <= DEFAULT_VALUES[i*VALUE_W +: VALUE_W];
            end
        end else if (wr_en_c) begin
            regs[time_param_sel] <= time_value;
        end
    end

    // State, countdown and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            busy      <= (state_next == RUNNING);
            expired   <= (state_next == DONE);
        end
    end

    // Next-state: a start in any state reloads (it beats a coincident tick);
    // the load uses the pre-write register contents.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        if (start_timer) begin
            remaining_next = value;
            state_next     = (value != '0) ? RUNNING : DONE;
        end else begin
            case (state)
                RUNNING: begin
                    if (tick) begin
                        if (remaining <= VALUE_W'(1)) begin
                            remaining_next = '0;
                            state_next     = DONE;
                        end else begin
                            remaining_next = remaining - VALUE_W'(1);
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer_bank.sv
// Directed bench for interval_timer_bank: expectations are queued when the
// stimulus is driven and popped/compared once the DUT has produced a result.
module tb_interval_timer_bank;

    localparam int unsigned NUM_PARAMS = 4;
    localparam int unsigned VALUE_W    = 4;
    localparam int unsigned SEL_W      = 2;

    logic               clock;
    logic               reset;
    logic [SEL_W-1:0]   time_param_sel;
    logic [VALUE_W-1:0] time_value;
    logic               reprogram;
    logic [SEL_W-1:0]   interval;
    logic               start_timer;
    logic               tick;
    logic [VALUE_W-1:0] value;
    logic [VALUE_W-1:0] remaining;
    logic               busy;
    logic               expired;
`ifdef TIMER_PARAM_LOCK_EN
    logic               reprogram_rejected;
`endif

    interval_timer_bank #(
        .NUM_PARAMS     (NUM_PARAMS),
        .VALUE_W        (VALUE_W),
        .DEFAULT_VALUES ({4'd10, 4'd15, 4'd8, 4'd6})
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .time_param_sel     (time_param_sel),
        .time_value         (time_value),
        .reprogram          (reprogram),
        .interval           (interval),
        .start_timer        (start_timer),
        .tick               (tick),
        .value              (value),
`ifdef TIMER_PARAM_LOCK_EN
        .reprogram_rejected (reprogram_rejected),
`endif
        .remaining          (remaining),
        .busy               (busy),
        .expired            (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed %0d with no expected value", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
            end
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_status(input string tag, input int rem, input int bsy, input int exp_pulse);
        expect_val({tag, "_remaining"}, 32'(rem));
        expect_val({tag, "_busy"},      32'(bsy));
        expect_val({tag, "_expired"},   32'(exp_pulse));
    endtask

    task automatic check_status();
        check_obs(32'(remaining));
        check_obs(32'(busy));
        check_obs(32'(expired));
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    int exp_def [4] = '{6, 8, 15, 10};

    initial begin
        reset          = 1'b0;
        time_param_sel = '0;
        time_value     = '0;
        reprogram      = 1'b0;
        interval       = '0;
        start_timer    = 1'b0;
        tick           = 1'b0;

        // Reset release away from the clock edge
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            interval = SEL_W'(i);
            expect_val("reset_value", 32'(exp_def[i]));
            #1;
            check_obs(32'(value));
        end
        expect_status("reset", 0, 0, 0);
        check_status();

        // Reprogram entry 2, visible the cycle after the write edge
        time_param_sel = 2'd2;
        time_value     = 4'd3;
        reprogram      = 1'b1;
        interval       = 2'd2;
        expect_val("no_bypass", 32'd15);
        #1;
        check_obs(32'(value));
        step();
        reprogram = 1'b0;
        expect_val("reprog_value", 32'd3);
        check_obs(32'(value));

        // No strobe, no write
        time_param_sel = 2'd1;
        time_value     = 4'd5;
        interval       = 2'd1;
        step();
        expect_val("no_strobe_value", 32'd8);
        check_obs(32'(value));

        // Countdown from entry 0; tick in load cycle ignored
        interval    = 2'd0;
        start_timer = 1'b1;
        tick        = 1'b1;
        expect_status("load", 6, 1, 0);
        step();
        start_timer = 1'b0;
        tick        = 1'b0;
        check_status();
        for (int k = 1; k <= 6; k++) begin
            repeat (4) step();
            if (k < 6) expect_status("count", 6 - k, 1, 0);
            else       expect_status("count_done", 0, 0, 1);
            do_tick();
            check_status();
        end
        expect_status("after_done", 0, 0, 0);
        step();
        check_status();

        // Zero-valued entry goes straight to DONE
        time_param_sel = 2'd3;
        time_value     = 4'd0;
        reprogram      = 1'b1;
        step();
        reprogram   = 1'b0;
        interval    = 2'd3;
        start_timer = 1'b1;
        expect_status("zero_load", 0, 0, 1);
        step();
        start_timer = 1'b0;
        check_status();
        expect_status("zero_after", 0, 0, 0);
        step();
        check_status();

        // Restart beats a coincident tick
        interval    = 2'd1;
        start_timer = 1'b1;
        expect_status("restart_load", 8, 1, 0);
        step();
        start_timer = 1'b0;
        check_status();
        repeat (3) begin
            do_tick();
            step();
        end
        expect_val("three_ticks", 32'd5);
        check_obs(32'(remaining));
        start_timer = 1'b1;
        tick        = 1'b1;
        expect_status("restart", 8, 1, 0);
        step();
        tick = 1'b0;
        check_status();

        // Same-edge reprogram of entry 1 with start loads the old value
        time_param_sel = 2'd1;
        time_value     = 4'd2;
        reprogram      = 1'b1;
        expect_status("coincident", 8, 1, 0);
        step();
        start_timer = 1'b0;
        reprogram   = 1'b0;
        check_status();
`ifdef TIMER_PARAM_LOCK_EN
        expect_val("locked_value", 32'd8);
        check_obs(32'(value));
        expect_val("rejected_pulse", 32'd1);
        check_obs(32'(reprogram_rejected));
        expect_val("rejected_clear", 32'd0);
        step();
        check_obs(32'(reprogram_rejected));
`else
        expect_val("coincident_write", 32'd2);
        check_obs(32'(value));
        step();
`endif
        // Countdown unaffected by the write
        expect_val("count_after_write", 32'd7);
        do_tick();
        check_obs(32'(remaining));
        repeat (3) do_tick();
        expect_status("pre_abort", 4, 1, 0);
        check_status();

        // Asynchronous abort mid-cycle
        #2 reset = 1'b0;
        #1;
        expect_status("abort", 0, 0, 0);
        check_status();
        expect_val("abort_regs", 32'd8);
        check_obs(32'(value));
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        expect_status("abort_after", 0, 0, 0);
        step();
        check_status();
        step();
        expect_status("abort_idle", 0, 0, 0);
        check_status();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_bank.md
Name: interval_timer_bank

Overview:
- Parametrised successor to the alarm's fixed four-entry time-parameter store.
- Holds NUM_PARAMS reprogrammable interval values of VALUE_W bits.
- Adds an integrated countdown timer: it loads the selected interval, decrements on each one-second tick and pulses expired at zero.
- Feeds the alarm control FSM, replacing its external counter.

Parameters:
- NUM_PARAMS, 4, number of interval registers (2..16).
- VALUE_W, 4, bit width of each interval value and of the countdown (1..16).
- DEFAULT_VALUES, {4'd10,4'd15,4'd8,4'd6}, packed reset values, NUM_PARAMS*VALUE_W bits; entry i is slice [i*VALUE_W +: VALUE_W].
- SEL_W, $clog2(NUM_PARAMS), derived localparam; selector width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- time_param_sel  input  SEL_W  register index for reprogram writes.
- time_value  input  VALUE_W  data for reprogram writes.
- reprogram  input  1  write strobe; one write per cycle it is high.
- interval  input  SEL_W  interval selected for value readout and for timer load.
- start_timer  input  1  load the selected interval and begin counting.
- tick  input  1  one-cycle-wide one-second enable.
- value  output  VALUE_W  combinational readout of register[interval].
- remaining  output  VALUE_W  current countdown value.
- busy  output  1  high while in the RUNNING state.
- expired  output  1  one-cycle pulse when the countdown completes.

Behaviour:
- Reset (reset=0, async) drives:
  - register[i] to DEFAULT_VALUES slice i;
  - state to IDLE;
  - remaining=0, busy=0, expired=0.
- Write: on a rising edge with reprogram=1 and time_param_sel<NUM_PARAMS, register[time_param_sel]<=time_value. An out-of-range sel ignores the write.
- Readout: value=register[interval] in the same cycle; an out-of-range interval reads 0.
- The readout reflects a write on the cycle after the write edge; there is no write-through bypass.
- FSM states: IDLE, RUNNING, DONE.
  - IDLE: start_timer=1 loads remaining<=register[interval].
    - If the loaded value is non-zero, go to RUNNING.
    - If it is zero, go directly to DONE.
    - tick is ignored in the load cycle.
  - RUNNING: tick=1 decrements remaining.
    - If remaining==1 on that tick, remaining<=0 and go to DONE.
    - start_timer=1 restarts: reload from register[interval]. Restart has priority over a coincident tick.
  - DONE: expired=1 for exactly one cycle, then go to IDLE. start_timer in DONE is treated as in IDLE, so a new load proceeds in that same cycle.
- busy=1 exactly when in RUNNING; expired=1 exactly when in DONE. Both are registered.
- The timer samples register[interval] before any same-edge write, so a coincident reprogram of the same entry loads the old value.
- Reprogramming during RUNNING does not alter the current countdown (no lock by default).
- remaining never wraps below 0; a tick while in IDLE or DONE has no effect.
- Reset asserted mid-count aborts immediately to the reset values; expired is not pulsed.

Optional Feature:
- Macro: TIMER_PARAM_LOCK_EN.
- When defined:
  - reprogram is ignored while busy=1.
  - Output port reprogram_rejected (1 bit, registered) pulses for one cycle after each ignored write attempt; it resets to 0.
  - Writes in IDLE or DONE are unaffected.
- When undefined:
  - The port is absent.
  - Writes are accepted in every state, as described above.

Test Plan:
- Reset release: check value for interval=0..3 reads 6,8,15,10; remaining=0, busy=0, expired=0.
- Reprogram: sel=2, time_value=3, one cycle, then interval=2 -> value=3 on the next cycle. sel=1 with reprogram=0 -> entry 1 remains 8.
- Countdown: interval=0 (6), pulse start_timer, then 6 ticks spaced 5 cycles apart:
  - remaining steps 6,5,4,3,2,1,0;
  - expired high exactly one cycle after the 6th tick edge;
  - busy falls at the same edge that expired rises.
- Zero load: program entry 3=0, start with interval=3 -> expired pulses on the cycle after start; busy never rises.
- Restart and coincidence:
  - Restart: start with interval=1 (8), after 3 ticks assert start_timer together with tick -> remaining=8, not 4.
  - Coincidence: same-edge reprogram of entry 1 to 2 with start_timer -> remaining=8.
- Async abort: assert reset mid-count (remaining=4) between clock edges -> busy and remaining drop to 0 immediately, no expired pulse.
- With TIMER_PARAM_LOCK_EN defined: reprogram during RUNNING -> register unchanged and reprogram_rejected pulses for one cycle.
